// File: rtl/seq_mul.sv
// Signed N x N shift-add multiplier with magnitude datapath; result and overflow flag after N+1 cycles.
// start is taken only in IDLE (including the done cycle); requests while busy are dropped.
module seq_mul #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] res,
  output logic         ovf
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [N-1:0]   res_q, res_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sign_q, sign_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  logic [N-1:0]   abs_a, abs_b;
  logic [2*N-1:0] prod;
  logic [N:0]     prod_top;

  always_comb begin
    // Negating the most negative value wraps to 2^(N-1), which is the exact magnitude as unsigned.
    abs_a    = a[N-1] ? -a : a;
    abs_b    = b[N-1] ? -b : b;
    prod     = sign_q ? -acc_q : acc_q;
    prod_top = prod[2*N-1:N-1];
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{N{1'b0}}, abs_a};
          mplier_d = abs_b;
          sign_d   = a[N-1] ^ b[N-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        res_d   = prod[N-1:0];
        // Representable only if the upper N+1 bits are a pure sign extension.
        ovf_d   = ~((&prod_top) | ~(|prod_top));
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign res  = res_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul at N=8 (directed corners, back-to-back, reset abort) and N=32 (random).
module tb_seq_mul;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    longint      due;
  } exp_t;

  localparam longint MAX32 = (longint'(1) << 31) - 1;
  localparam longint MIN32 = -(longint'(1) << 31);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, start32;
  logic [7:0]  a8, b8, res8;
  logic [31:0] a32, b32, res32;
  logic        busy8, done8, ovf8;
  logic        busy32, done32, ovf32;

  int     checks = 0;
  int     failures = 0;
  int     n_done8 = 0, n_done32 = 0;
  int     n_push8 = 0, n_push32 = 0;
  longint cyc = 0;
  exp_t   q8[$];
  exp_t   q32[$];

  seq_mul #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .res(res8), .ovf(ovf8)
  );

  seq_mul #(.N(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .res(res32), .ovf(ovf32)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input bit push);
    exp_t   e;
    longint p;
    a8 = x; b8 = y; start8 = 1'b1;
    p = longint'($signed(x)) * longint'($signed(y));
    e.res = {56'd0, p[7:0]};
    e.ovf = (p > 127) || (p < -128);
    e.due = cyc + 10;
    if (push) begin
      q8.push_back(e);
      n_push8++;
    end
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint p;
    a32 = x; b32 = y; start32 = 1'b1;
    p = longint'($signed(x)) * longint'($signed(y));
    e.res = {32'd0, p[31:0]};
    e.ovf = (p > MAX32) || (p < MIN32);
    e.due = cyc + 34;
    q32.push_back(e);
    n_push32++;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8) begin
      n_done8++;
      chk("busy_with_done8", 64'(busy8), 64'd0);
      if (q8.size() == 0) begin
        chk("extra_done8", 64'(done8), 64'd0);
      end else begin
        e = q8.pop_front();
        chk("res8", 64'(res8), e.res);
        chk("ovf8", 64'(ovf8), 64'(e.ovf));
        chk("lat8", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (done32) begin
      n_done32++;
      chk("busy_with_done32", 64'(busy32), 64'd0);
      if (q32.size() == 0) begin
        chk("extra_done32", 64'(done32), 64'd0);
      end else begin
        e = q32.pop_front();
        chk("res32", 64'(res32), e.res);
        chk("ovf32", 64'(ovf32), 64'(e.ovf));
        chk("lat32", cyc, e.due);
      end
    end
  end

  initial begin
    logic [7:0]  ta[5];
    logic [7:0]  tb_[5];
    logic [31:0] ca[6];
    logic [31:0] cb[6];
    logic [31:0] x, y;

    rst_n = 1'b0; start8 = 1'b0; start32 = 1'b0;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_res8", 64'(res8), 64'd0);
    chk("rst_ovf8", 64'(ovf8), 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_res32", 64'(res32), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 7 * -3 with cycle-by-cycle busy/done profile; operands scrambled while busy.
    issue8(8'd7, 8'hFD, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
      chk("busy_calc8", 64'(busy8), 64'd1);
      chk("done_early8", 64'(done8), 64'd0);
    end
    @(negedge clk);
    chk("done_at9", 64'(done8), 64'd1);
    chk("busy_at9", 64'(busy8), 64'd0);
    @(negedge clk);
    chk("done_pulse_width", 64'(done8), 64'd0);

    ta  = '{8'h80, 8'hF8, 8'd16, 8'd0, 8'h80};
    tb_ = '{8'hFF, 8'd16, 8'd16, 8'hFB, 8'h80};
    for (int i = 0; i < 5; i++) begin
      issue8(ta[i], tb_[i], 1'b1);
      repeat (10) @(negedge clk);
    end

    // Back-to-back: two ignored starts while busy, then a new op in the done cycle.
    issue8(8'd6, 8'hF9, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      if (k == 3 || k == 5) begin
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    @(negedge clk);
    chk("b2b_done_cycle", 64'(done8), 64'd1);
    issue8(8'd3, 8'd4, 1'b1);
    chk("b2b_res_held", 64'(res8), 64'hD6);
    repeat (10) @(negedge clk);

    // Reset mid-CALC aborts without done, then a fresh op right after release.
    issue8(8'd9, 8'd9, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy8", 64'(busy8), 64'd0);
    chk("arst_done8", 64'(done8), 64'd0);
    chk("arst_res8", 64'(res8), 64'd0);
    chk("arst_ovf8", 64'(ovf8), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue8(8'd5, 8'd5, 1'b1);
    repeat (12) @(negedge clk);
    chk("post_rst_res8", 64'(res8), 64'h19);

    // N=32 random run, issued back-to-back in each done cycle.
    ca = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0001_0000};
    cb = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_8000};
    for (int i = 0; i < 1000; i++) begin
      if (i < 6) begin
        x = ca[i]; y = cb[i];
      end else if (i % 4 == 1) begin
        x = 32'($signed(16'($urandom))); y = 32'($signed(16'($urandom)));
      end else begin
        x = $urandom; y = $urandom;
      end
      issue32(x, y);
      repeat (33) @(negedge clk);
    end
    repeat (36) @(negedge clk);

    chk("sb8_empty", 64'(q8.size()), 64'd0);
    chk("sb32_empty", 64'(q32.size()), 64'd0);
    chk("done_count8", 64'(n_done8), 64'(n_push8));
    chk("done_count32", 64'(n_done32), 64'(n_push32));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand and result width in bits; legal range is 4..64.
REQ-002 Port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide, and be the reset: asynchronous assertion, active-low.
REQ-004 Port start SHALL be an input, 1 bit wide, requesting an operation; it is sampled only in IDLE.
REQ-005 Port a SHALL be an input, N bits wide, carrying the multiplicand as two's-complement signed.
REQ-006 Port b SHALL be an input, N bits wide, carrying the multiplier as two's-complement signed.
REQ-007 Port busy SHALL be an output, 1 bit wide, high while an operation is in progress.
REQ-008 Port done SHALL be an output, 1 bit wide, a single-cycle pulse when res and ovf become valid.
REQ-009 Port res SHALL be an output, N bits wide, carrying the low N bits of the signed product a*b.
REQ-010 Port ovf SHALL be an output, 1 bit wide, high when the true 2N-bit signed product is not representable in N bits.

Function
REQ-011 The block SHALL have the states IDLE, CALC and SIGN.
REQ-012 In IDLE, on a rising edge with start=1, the block SHALL:
- capture |a| and |b| as N-bit unsigned values (|-2^(N-1)| = 2^(N-1) is exact);
- capture sign = a[N-1]^b[N-1];
- clear the 2N-bit accumulator and the iteration counter;
- go to CALC.
REQ-013 In IDLE with start=0, the block SHALL hold state, res and ovf.
REQ-014 Each CALC edge SHALL perform one shift-add step:
- if the multiplier LSB is 1, add the shifted multiplicand to the accumulator;
- shift the multiplier right and the multiplicand left by 1;
- increment the counter.
REQ-015 After exactly N CALC edges the block SHALL go to SIGN.
REQ-016 On the SIGN edge, the block SHALL form P = sign ? -acc : acc (2N-bit two's complement), load res = P[N-1:0], load ovf = (P[2N-1:N-1] not all equal), pulse done, and return to IDLE.
REQ-017 If acc = 0 and sign = 1, P SHALL equal 0 (no negative zero), giving ovf = 0.
REQ-018 Latency SHALL be fixed at N+1 cycles after the start capture edge:
- done is high in the cycle following edge N+1;
- busy is high from after the capture edge until done rises;
- busy and done are never high together.
REQ-019 start SHALL be ignored while busy=1; operand changes during busy SHALL NOT affect the result.
REQ-020 start=1 in the cycle done is high SHALL be accepted (back-to-back), while res/ovf keep the completed result until the next SIGN edge.
REQ-021 res and ovf SHALL hold their last value until the next SIGN edge.

Reset
REQ-022 When rst_n=0, the block SHALL, asynchronously: go to IDLE; set busy=0, done=0, res=0, ovf=0; clear the accumulator and counter.
REQ-023 Reset asserted mid-operation SHALL abort the operation without a done pulse.
REQ-024 After rst_n deasserts, the first rising edge SHALL sample start normally.

Verification
REQ-025 With N=8, a=7, b=-3 (0xFD), start for one cycle, the bench SHALL check res=0xEB (-21), ovf=0, done exactly 9 cycles after the capture edge, and busy high for cycles 1..8.
REQ-026 With N=8, a=-128 (0x80), b=-1 (0xFF), the bench SHALL check res=0x80, ovf=1; and with a=-8, b=16, res=0x80, ovf=0.
REQ-027 With N=8, a=16, b=16, the bench SHALL check res=0x00, ovf=1; and with a=0, b=-5, res=0x00, ovf=0.
REQ-028 With N=8, the bench SHALL pulse start twice while busy, then once in the done cycle with new operands 3*4, and check only two results (first, then 0x0C) with no dropped or extra done pulse.
REQ-029 The bench SHALL drive rst_n=0 at CALC cycle 4, then check: busy, done, res and ovf all 0 immediately (before the next clk edge); no done pulse; a fresh 5*5 gives res=0x19 after 9 cycles.
REQ-030 With N=32, the bench SHALL run 1000 random operand pairs against a 64-bit signed reference model, checking res, ovf and latency=33.
